// File: rtl/usb_in_ep_rr_arb.sv
// Round-robin arbiter sharing one USB IN endpoint buffer between NUM_REQ requesters.
// Ownership is held for a whole packet; priority rotates between packets.
module usb_in_ep_rr_arb #(
  parameter int NUM_REQ = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_in,
  output logic [NUM_REQ-1:0]     grant_out,
  input  logic [NUM_REQ-1:0]     data_put_in,
  input  logic [8*NUM_REQ-1:0]   data_in,
  input  logic [NUM_REQ-1:0]     data_done_in,
  input  logic [NUM_REQ-1:0]     stall_in,
  output logic [NUM_REQ-1:0]     data_free_out,
  output logic [NUM_REQ-1:0]     acked_out,
  output logic                   ep_req,
  input  logic                   ep_grant,
  input  logic                   ep_data_free,
  output logic                   ep_data_put,
  output logic [7:0]             ep_data,
  output logic                   ep_data_done,
  output logic                   ep_stall,
  input  logic                   ep_acked
);

  localparam int OW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, REQ, OWN, GAP} state_t;

  state_t        state_q, state_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] last_q, last_d;

  logic [OW-1:0]      pick;
  logic               found;
  logic [OW:0]        cand;
  logic [NUM_REQ-1:0] owner_oh;
  logic               in_own;
  logic               gnt;

  // Search starts just after the last released owner; the extra bit keeps the
  // wrap exact for non-power-of-two NUM_REQ.
  always_comb begin
    pick  = last_q;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_q} + (OW+1)'(k);
      if (cand >= (OW+1)'(NUM_REQ)) begin
        cand = cand - (OW+1)'(NUM_REQ);
      end
      if (!found && req_in[cand[OW-1:0]]) begin
        pick  = cand[OW-1:0];
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (|req_in) begin
          owner_d = pick;
          state_d = REQ;
        end
      end
      REQ: begin
        if (!req_in[owner_q]) begin
          state_d = GAP;
        end else if (ep_grant) begin
          state_d = OWN;
        end
      end
      OWN: begin
        if (data_done_in[owner_q] || !req_in[owner_q]) begin
          last_d  = owner_q;
          state_d = GAP;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= OW'(NUM_REQ-1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    owner_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      owner_oh[i] = (owner_q == OW'(i));
    end
  end

  // Everything returned or forwarded is gated by ownership; acked ignores ep_grant.
  always_comb begin
    in_own        = (state_q == OWN);
    gnt           = in_own && ep_grant;
    ep_req        = (state_q == REQ) || in_own;
    grant_out     = gnt ? owner_oh : '0;
    data_free_out = ep_data_free ? grant_out : '0;
    acked_out     = (in_own && ep_acked) ? owner_oh : '0;
    ep_data_put   = gnt && data_put_in[owner_q];
    ep_data_done  = gnt && data_done_in[owner_q];
    ep_stall      = gnt && stall_in[owner_q];
    ep_data       = in_own ? data_in[{owner_q, 3'b000} +: 8] : 8'h00;
  end

endmodule

// File: tb/tb_usb_in_ep_rr_arb.sv
// Scoreboard bench for usb_in_ep_rr_arb: directed packets push expected endpoint
// transfers; a negedge monitor pops and compares every forwarded put/done.
module tb_usb_in_ep_rr_arb;

  logic        clk;
  logic        reset;
  logic [3:0]  req_in;
  logic [3:0]  grant_out;
  logic [3:0]  data_put_in;
  logic [31:0] data_in;
  logic [3:0]  data_done_in;
  logic [3:0]  stall_in;
  logic [3:0]  data_free_out;
  logic [3:0]  acked_out;
  logic        ep_req;
  logic        ep_grant;
  logic        ep_data_free;
  logic        ep_data_put;
  logic [7:0]  ep_data;
  logic        ep_data_done;
  logic        ep_stall;
  logic        ep_acked;

  typedef struct packed {
    logic [3:0] grant;
    logic [7:0] data;
    logic       put;
    logic       done;
  } xfer_t;

  xfer_t exp_q[$];
  xfer_t mon_got;
  xfer_t mon_exp;

  int n_compared;
  int n_mismatched;

  usb_in_ep_rr_arb #(.NUM_REQ(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_in       (req_in),
    .grant_out    (grant_out),
    .data_put_in  (data_put_in),
    .data_in      (data_in),
    .data_done_in (data_done_in),
    .stall_in     (stall_in),
    .data_free_out(data_free_out),
    .acked_out    (acked_out),
    .ep_req       (ep_req),
    .ep_grant     (ep_grant),
    .ep_data_free (ep_data_free),
    .ep_data_put  (ep_data_put),
    .ep_data      (ep_data),
    .ep_data_done (ep_data_done),
    .ep_stall     (ep_stall),
    .ep_acked     (ep_acked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 2 units later.
  task automatic applyStimulus(input logic rst, input logic [3:0] req, input logic [3:0] put,
                               input logic [3:0] done, input logic [3:0] stall,
                               input logic [31:0] data, input logic grant, input logic ack);
    @(posedge clk);
    #1;
    reset        = rst;
    req_in       = req;
    data_put_in  = put;
    data_done_in = done;
    stall_in     = stall;
    data_in      = data;
    ep_grant     = grant;
    ep_acked     = ack;
    #2;
  endtask

  function automatic logic [31:0] lanes(input int owner, input logic [7:0] b);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) begin
      v[8*i +: 8] = (i == owner) ? b : ~b;
    end
    return v;
  endfunction

  function automatic logic [31:0] out_bundle();
    return 32'({ep_req, ep_data_put, ep_data_done, ep_stall, ep_data,
                grant_out, data_free_out, acked_out});
  endfunction

  task automatic resetDut();
    applyStimulus(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'hF, 4'hF, 4'h0, 4'hF, 32'hFFFF_FFFF, 1'b1, 1'b1);
    checkOutput("reset_outputs_zero", out_bundle(), 32'h0);
  endtask

  // One full packet starting in IDLE: IDLE, REQ, nbytes puts, done, GAP.
  task automatic do_packet(input int owner, input logic [3:0] mask, input int nbytes,
                           input logic [7:0] base);
    logic [3:0] oh;
    logic [7:0] byt;
    oh = 4'b0001 << owner;
    applyStimulus(1'b0, mask, mask, 4'h0, 4'h0, lanes(owner, 8'hEE), 1'b1, 1'b0);
    checkOutput("idle_outputs_zero", out_bundle(), 32'h0);
    applyStimulus(1'b0, mask, 4'h0, 4'h0, 4'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("req_ep_req", 32'(ep_req), 32'h1);
    checkOutput("req_no_grant", 32'(grant_out), 32'h0);
    for (int b = 0; b < nbytes; b++) begin
      byt = base + 8'(b) * 8'h22;
      applyStimulus(1'b0, mask, mask, 4'h0, 4'h0, lanes(owner, byt), 1'b1, 1'b0);
      exp_q.push_back('{grant: oh, data: byt, put: 1'b1, done: 1'b0});
      checkOutput("own_grant", 32'(grant_out), 32'(oh));
    end
    applyStimulus(1'b0, mask, 4'h0, oh, 4'h0, 32'h0, 1'b1, 1'b0);
    exp_q.push_back('{grant: oh, data: 8'h00, put: 1'b0, done: 1'b1});
    applyStimulus(1'b0, mask, 4'h0, 4'h0, 4'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("gap_ep_req_low", 32'(ep_req), 32'h0);
    checkOutput("gap_no_grant", 32'(grant_out), 32'h0);
  endtask

  // Monitor: every forwarded put or done must match the next expected transfer.
  always @(negedge clk) begin
    if (ep_data_put === 1'b1 || ep_data_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL sb_unexpected: got grant=%b put=%b done=%b data=0x%0h expected no transfer at %0t",
                 grant_out, ep_data_put, ep_data_done, ep_data, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_got = '{grant: grant_out, data: (mon_exp.put ? ep_data : 8'h00),
                    put: ep_data_put, done: ep_data_done};
        checkOutput("sb_xfer", 32'(mon_got), 32'(mon_exp));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    reset        = 1'b1;
    req_in       = '0;
    data_put_in  = '0;
    data_in      = '0;
    data_done_in = '0;
    stall_in     = '0;
    ep_grant     = 1'b1;
    ep_data_free = 1'b1;
    ep_acked     = 1'b0;

    // Single requester 2, three bytes then done
    resetDut();
    do_packet(2, 4'b0100, 3, 8'h12);

    // All requesting: rotation 0,1,2,3,0
    resetDut();
    for (int k = 0; k < 5; k++) begin
      do_packet(k % 4, 4'b1111, 2, 8'h40 + 8'(k));
    end

    // Wrap after last=1
    resetDut();
    do_packet(1, 4'b0010, 1, 8'h21);
    do_packet(0, 4'b0011, 1, 8'h23);
    do_packet(1, 4'b0011, 1, 8'h25);

    // Endpoint grant withdrawn during OWN
    resetDut();
    applyStimulus(1'b0, 4'b0001, 4'h0, 4'h0, 4'h0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'b0001, 4'h0, 4'h0, 4'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("t4_req_ep_req", 32'(ep_req), 32'h1);
    applyStimulus(1'b0, 4'b0001, 4'b0001, 4'h0, 4'h0, lanes(0, 8'h21), 1'b1, 1'b0);
    exp_q.push_back('{grant: 4'b0001, data: 8'h21, put: 1'b1, done: 1'b0});
    checkOutput("t4_data_free", 32'(data_free_out), 32'h1);
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b0, 4'b0001, 4'b0001, 4'h0, 4'h0, lanes(0, 8'h99), 1'b0, (c == 2));
      checkOutput("t4_hold_grant_zero", 32'(grant_out), 32'h0);
      checkOutput("t4_hold_put_zero", 32'(ep_data_put), 32'h0);
      checkOutput("t4_hold_ep_req", 32'(ep_req), 32'h1);
      checkOutput("t4_hold_free_zero", 32'(data_free_out), 32'h0);
      checkOutput("t4_hold_ep_data", 32'(ep_data), 32'h99);
      if (c == 2) begin
        checkOutput("t4_acked_owner", 32'(acked_out), 32'h1);
      end
    end
    applyStimulus(1'b0, 4'b0001, 4'b0001, 4'h0, 4'h0, lanes(0, 8'h77), 1'b1, 1'b0);
    exp_q.push_back('{grant: 4'b0001, data: 8'h77, put: 1'b1, done: 1'b0});
    checkOutput("t4_resume_grant", 32'(grant_out), 32'h1);
    applyStimulus(1'b0, 4'b0001, 4'h0, 4'h0, 4'b0001, 32'h0, 1'b1, 1'b0);
    checkOutput("t4_stall_fwd", 32'(ep_stall), 32'h1);
    applyStimulus(1'b0, 4'b0001, 4'h0, 4'h0, 4'b0001, 32'h0, 1'b0, 1'b0);
    checkOutput("t4_stall_gated", 32'(ep_stall), 32'h0);
    applyStimulus(1'b0, 4'b0001, 4'h0, 4'b0001, 4'h0, 32'h0, 1'b1, 1'b0);
    exp_q.push_back('{grant: 4'b0001, data: 8'h00, put: 1'b0, done: 1'b1});
    applyStimulus(1'b0, 4'b0001, 4'h0, 4'h0, 4'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("t4_gap_ep_req_low", 32'(ep_req), 32'h0);

    // Requester 3 abandons in REQ; last stays 3 so requester 0 wins next
    resetDut();
    applyStimulus(1'b0, 4'b1000, 4'h0, 4'h0, 4'h0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b0000, 4'h0, 4'h0, 4'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("t5_req_ep_req", 32'(ep_req), 32'h1);
    checkOutput("t5_req_no_grant", 32'(grant_out), 32'h0);
    applyStimulus(1'b0, 4'b0000, 4'h0, 4'h0, 4'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("t5_gap_ep_req_low", 32'(ep_req), 32'h0);
    checkOutput("t5_gap_no_grant", 32'(grant_out), 32'h0);
    do_packet(0, 4'b1001, 1, 8'h31);
    do_packet(3, 4'b1001, 1, 8'h35);

    // Reset in the middle of a packet
    resetDut();
    applyStimulus(1'b0, 4'b0100, 4'h0, 4'h0, 4'h0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'b0100, 4'h0, 4'h0, 4'h0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'b0100, 4'b0100, 4'h0, 4'h0, lanes(2, 8'h5A), 1'b1, 1'b0);
    exp_q.push_back('{grant: 4'b0100, data: 8'h5A, put: 1'b1, done: 1'b0});
    applyStimulus(1'b1, 4'b0100, 4'h0, 4'h0, 4'h0, 32'h0, 1'b1, 1'b0);
    do_packet(0, 4'b1111, 1, 8'h60);

    @(negedge clk);
    #1;
    n_compared++;
    if (exp_q.size() != 0) begin
      n_mismatched++;
      $display("[TB] FAIL sb_missing: got %0d transfers outstanding expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
